spi_slave_regs: RTL

SPI peripheral (slave) endpoint inside the FPGA: receives command frames from the host controller on spi_clk/spi_mosi/spi_cs, returns read data on spi_miso, and converts each frame into single-cycle register-bus transactions in the clk_12mhz domain. It sits between the top-level SPI pins and the configuration/status register file (relay, comparator, selector and counter controls).

---
 rtl/spi_slave_regs.sv | 113 +++++++++++
 1 files changed

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-1 slave bridging command frames to a single-cycle register bus; SPI_SLAVE_BURST_EN enables address-incrementing bursts
module spi_slave_regs #(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_12mhz,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              frame_done,
    output logic              frame_err
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
    state_t state_q;
    logic [SYNC_STAGES:0] sclk_q, mosi_q, cs_q;
    logic [2:0] bit_q;
    logic [6:0] rx_q;
    logic [7:0] rx_d, tx_q;
    logic sclk_rise, sclk_fall, mosi_s, cs_s;
    logic wr_q, arm_q, miso_q, inc_q, done_q;
    // Top flop of each chain is the edge-detect stage; earlier flops are the synchronizer
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign mosi_s    = mosi_q[SYNC_STAGES];
    assign cs_s      = cs_q[SYNC_STAGES];
    assign rx_d      = {rx_q, mosi_s};
    assign spi_miso  = (state_q == IDLE) ? 1'bz : miso_q;
    // Pin synchronizers plus edge-detect stage; left unreset so a reset cannot fake a CS edge
    always_ff @(posedge clk_12mhz) begin
        sclk_q <= {sclk_q[SYNC_STAGES-1:0], spi_clk};
        mosi_q <= {mosi_q[SYNC_STAGES-1:0], spi_mosi};
        cs_q   <= {cs_q[SYNC_STAGES-1:0], spi_cs};
    end
    // Frame FSM: shifts bits, issues bus strobes and frame status pulses
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state_q    <= IDLE;
            arm_q      <= 1'b0;
            bit_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            wr_q       <= 1'b0;
            miso_q     <= 1'b0;
            inc_q      <= 1'b0;
            done_q     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_rd     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            reg_we     <= 1'b0;
            reg_rd     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            inc_q      <= 1'b0;
            if (reg_rd) tx_q <= reg_rdata;
            if (inc_q) begin
                reg_addr <= reg_addr + 1'b1;
                reg_rd   <= ~wr_q;
            end
            if (cs_s) begin
                if (state_q != IDLE) begin
                    frame_done <= (bit_q == 3'd0) && (state_q == DATA);
                    frame_err  <= (bit_q != 3'd0);
                end
                state_q <= IDLE;
                arm_q   <= 1'b1;
                bit_q   <= '0;
                tx_q    <= '0;
                wr_q    <= 1'b0;
                miso_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (state_q == IDLE) begin
                if (arm_q) state_q <= CMD;
            end else begin
                if (sclk_rise) begin
                    miso_q <= tx_q[7];
                    tx_q   <= tx_q << 1;
                end
                if (sclk_fall) begin
                    rx_q  <= rx_d[6:0];
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        if (state_q == CMD) begin
                            state_q  <= DATA;
                            wr_q     <= rx_d[7];
                            reg_addr <= ADDR_W'(rx_d[6:0]);
                            reg_rd   <= ~rx_d[7];
                            tx_q     <= '0;
                        end else if (!done_q) begin
                            reg_we <= wr_q;
                            if (wr_q) reg_wdata <= rx_d;
`ifdef SPI_SLAVE_BURST_EN
                            inc_q <= 1'b1;
`else
                            done_q <= 1'b1;
`endif
                        end
                    end
                end
            end
        end
    end
endmodule
